// File: rtl/clk_ratio_ctrl.sv
// Division-ratio switch controller: accepts a new ratio, swaps it in on a falling
// edge of the fed-back divided clock, then waits for it to settle or times out.
module clk_ratio_ctrl #(
    parameter int N            = 4,
    parameter int DEF_RATIO    = 4,
    parameter int SETTLE_EDGES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic         i_ref_clk,
    input  logic         i_rst_n,
    input  logic         i_req_valid,
    input  logic [N-1:0] i_req_ratio,
    input  logic         i_div_clk,
    output logic         o_req_ready,
    output logic [N-1:0] o_div_ratio,
    output logic         o_clk_en,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = $clog2(SETTLE_EDGES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
    localparam logic [EW-1:0] EDGE_LAST = EW'(SETTLE_EDGES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        SETTLE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  fallback_q, fallback_d;
    logic [N-1:0]  ratio_d;
    logic [EW-1:0] edge_q, edge_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          div_q;
    logic          done_d, err_d;

    logic accept, div_fall, div_rise, tmo_hit;

    assign accept   = i_req_valid && o_req_ready;
    assign div_fall = div_q && !i_div_clk;
    assign div_rise = !div_q && i_div_clk;
    assign tmo_hit  = (tmo_q == TMO_LAST);

    // Edge/timeout priority: a qualifying divider edge is checked before the timeout.
    always_comb begin
        // NOTE: every next-value gets a default first so no path can infer a latch.
        state_d    = state_q;
        pend_d     = pend_q;
        fallback_d = fallback_q;
        ratio_d    = o_div_ratio;
        edge_d     = edge_q;
        tmo_d      = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (accept) begin
                    pend_d = i_req_ratio;
                    if (i_req_ratio < N'(2)) begin
                        err_d = 1'b1;
                    end else if (i_req_ratio == o_div_ratio) begin
                        done_d = 1'b1;
                    end else begin
                        fallback_d = o_div_ratio;
                        state_d    = WAIT_EDGE;
                    end
                end
            end
            WAIT_EDGE: begin
                if (div_fall) begin
                    ratio_d = pend_q;
                    edge_d  = '0;
                    tmo_d   = '0;
                    state_d = SETTLE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (div_rise) begin
                    edge_d = edge_q + 1'b1;
                    if (edge_q == EDGE_LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (tmo_hit) begin
                    ratio_d = fallback_q;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            fallback_q  <= N'(DEF_RATIO);
            edge_q      <= '0;
            tmo_q       <= '0;
            div_q       <= 1'b0;
            o_div_ratio <= N'(DEF_RATIO);
            o_clk_en    <= 1'b0;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            state_q     <= state_d;
            pend_q      <= pend_d;
            fallback_q  <= fallback_d;
            edge_q      <= edge_d;
            tmo_q       <= tmo_d;
            div_q       <= i_div_clk;
            o_div_ratio <= ratio_d;
            o_clk_en    <= 1'b1;
            o_req_ready <= (state_d == IDLE);
            o_busy      <= (state_d != IDLE);
            o_done      <= done_d;
            o_err       <= err_d;
        end
    end

endmodule

// File: tb/tb_clk_ratio_ctrl.sv
// Bench for clk_ratio_ctrl: a transaction-level model checked every cycle plus
// directed scenarios with hand-computed timing expectations.
`timescale 1ns/1ps
module tb_clk_ratio_ctrl;

    localparam int N            = 4;
    localparam int DEF_RATIO    = 4;
    localparam int SETTLE_EDGES = 2;
    localparam int TIMEOUT      = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic [N-1:0] req_ratio = '0;
    logic         div_clk = 1'b0;
    logic         req_ready, clk_en, busy, done, err;
    logic [N-1:0] div_ratio;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    clk_ratio_ctrl #(
        .N(N), .DEF_RATIO(DEF_RATIO), .SETTLE_EDGES(SETTLE_EDGES), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_ref_clk  (clk),
        .i_rst_n    (rst_n),
        .i_req_valid(req_valid),
        .i_req_ratio(req_ratio),
        .i_div_clk  (div_clk),
        .o_req_ready(req_ready),
        .o_div_ratio(div_ratio),
        .o_clk_en   (clk_en),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream divider: high for ratio/2 ref cycles, low for the rest; can be frozen.
    bit freeze = 1'b0;
    int dcnt   = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (!clk_en) begin
            dcnt    = 0;
            div_clk = 1'b0;
        end else if (!freeze) begin
            if (dcnt >= int'(div_ratio) - 1) dcnt = 0;
            else dcnt++;
            div_clk = (dcnt < int'(div_ratio) / 2);
        end
    end

    // Model: one record per switch in flight, ages counted in ref cycles.
    typedef struct {
        logic [N-1:0] ratio;
        bit           ready, busy, en, done, err;
        bit           active, switched;
        logic [N-1:0] target, fallback;
        int           age, rises;
        bit           prev_div;
    } model_t;

    function automatic model_t model_reset();
        model_t s;
        s.ratio = N'(DEF_RATIO);
        s.ready = 0; s.busy = 0; s.en = 0; s.done = 0; s.err = 0;
        s.active = 0; s.switched = 0;
        s.target = '0; s.fallback = '0;
        s.age = 0; s.rises = 0; s.prev_div = 0;
        return s;
    endfunction

    function automatic model_t step(input model_t s, input bit valid,
                                    input logic [N-1:0] r, input bit dclk);
        model_t n   = s;
        bit    fall = s.prev_div && !dclk;
        bit    rise = !s.prev_div && dclk;
        n.done = 0; n.err = 0; n.en = 1; n.prev_div = dclk;
        if (!s.active) begin
            if (valid && s.ready) begin
                if (int'(r) < 2) n.err = 1;
                else if (r == s.ratio) n.done = 1;
                else begin
                    n.active = 1; n.switched = 0; n.target = r;
                    n.fallback = s.ratio; n.age = 0;
                end
            end
        end else if (!s.switched) begin
            n.age = s.age + 1;
            if (fall) begin
                n.ratio = s.target; n.switched = 1; n.age = 0; n.rises = 0;
            end else if (n.age == TIMEOUT) begin
                n.err = 1; n.active = 0;
            end
        end else begin
            n.age = s.age + 1;
            if (rise) begin
                n.rises = s.rises + 1;
                if (n.rises == SETTLE_EDGES) begin n.done = 1; n.active = 0; end
            end else if (n.age == TIMEOUT) begin
                n.ratio = s.fallback; n.err = 1; n.active = 0;
            end
        end
        n.ready = !n.active;
        n.busy  = n.active;
        return n;
    endfunction

    model_t m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= step(m, req_valid, req_ratio, div_clk);
    end

    int           done_cnt = 0;
    int           err_cnt  = 0;
    logic [N-1:0] done_log[$];

    always @(negedge clk) begin
        check("div_ratio", int'(div_ratio), int'(m.ratio));
        check("req_ready", int'(req_ready), int'(m.ready));
        check("busy",      int'(busy),      int'(m.busy));
        check("clk_en",    int'(clk_en),    int'(m.en));
        check("done",      int'(done),      int'(m.done));
        check("err",       int'(err),       int'(m.err));
        if (done) begin done_cnt++; done_log.push_back(div_ratio); end
        if (err) err_cnt++;
    end

    // Holds valid from a negedge until accepted; returns on the negedge after acceptance.
    task automatic req_held(input logic [N-1:0] r);
        int k = 0;
        req_ratio = r;
        req_valid = 1'b1;
        while (!req_ready && k < 400) begin @(negedge clk); k++; end
        check("accept_wait", int'(k < 400), 1);
        @(negedge clk);
    endtask

    task automatic do_req(input logic [N-1:0] r);
        req_held(r);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin @(negedge clk); k++; end
        check("idle_wait", int'(k < 400), 1);
        @(negedge clk);
    endtask

    task automatic wait_ratio(input logic [N-1:0] r);
        int k = 0;
        while (div_ratio != r && k < 400) begin @(negedge clk); k++; end
        check("ratio_wait", int'(k < 400), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, rises, base, d0, e0;
        bit prev;
        int edges[$];

        repeat (3) @(negedge clk);
        check("rst_clk_en", int'(clk_en), 0);
        check("rst_ratio", int'(div_ratio), 4);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_clk_en", int'(clk_en), 1);
        check("first_ready", int'(req_ready), 1);
        check("first_ratio", int'(div_ratio), 4);
        repeat (4) @(negedge clk);

        // Rejected and trivial requests
        do_req(4'd0);
        check("r0_err", int'(err), 1);
        check("r0_ratio", int'(div_ratio), 4);
        do_req(4'd1);
        check("r1_err", int'(err), 1);
        do_req(4'd4);
        check("r4_done", int'(done), 1);
        check("r4_busy", int'(busy), 0);

        // 4 -> 6 switch
        do_req(4'd6);
        check("r6_busy", int'(busy), 1);
        wait_ratio(4'd6);
        check("r6_fall_level", int'(div_clk), 0);
        prev = div_clk; rises = 0; k = 0;
        while (!done && k < 200) begin
            @(negedge clk); k++;
            if (!prev && div_clk) rises++;
            prev = div_clk;
        end
        check("r6_rises_before_done", rises, 2);
        k = 0; prev = div_clk;
        while (edges.size() < 2 && k < 100) begin
            @(negedge clk); k++;
            if (!prev && div_clk) edges.push_back(k);
            prev = div_clk;
        end
        check("r6_period", (edges.size() == 2) ? edges[1] - edges[0] : -1, 6);
        wait_idle();

        // Back to 4, then WAIT_EDGE timeout with a stuck-low divider
        do_req(4'd4);
        wait_idle();
        k = 0;
        while (div_clk && k < 20) begin @(negedge clk); k++; end
        freeze = 1'b1;
        repeat (2) @(negedge clk);
        do_req(4'd8);
        k = 1;
        while (!err && k < 200) begin @(negedge clk); k++; end
        check("wait_tmo_cycle", k, 65);
        check("wait_tmo_ratio", int'(div_ratio), 4);
        freeze = 1'b0;
        repeat (10) @(negedge clk);

        // SETTLE timeout: freeze right after the swap, expect fallback to 4
        do_req(4'd8);
        wait_ratio(4'd8);
        freeze = 1'b1;
        k = 1;
        while (!err && k < 200) begin @(negedge clk); k++; end
        check("settle_tmo_cycle", k, 65);
        check("settle_tmo_ratio", int'(div_ratio), 4);
        freeze = 1'b0;
        repeat (10) @(negedge clk);

        // Odd ratio, then held back-to-back requests
        do_req(4'd5);
        wait_idle();
        check("r5_ratio", int'(div_ratio), 5);
        base = done_log.size();
        req_held(4'd3);
        req_held(4'd7);
        req_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        check("b2b_done_count", done_log.size() - base, 2);
        if (done_log.size() - base == 2) begin
            check("b2b_first", int'(done_log[base]), 3);
            check("b2b_second", int'(done_log[base+1]), 7);
        end
        check("b2b_ratio", int'(div_ratio), 7);

        // Reset in the middle of SETTLE
        do_req(4'd6);
        wait_ratio(4'd6);
        check("mid_settle_busy", int'(busy), 1);
        @(negedge clk);
        d0 = done_cnt; e0 = err_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("abort_ratio", int'(div_ratio), 4);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_err", int'(err), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_err", err_cnt - e0, 0);
        check("abort_ready", int'(req_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
